// File: rtl/dmem_responder_pkg.sv
// Shared types and constants for the data-memory responder.
package dmem_responder_pkg;

    localparam int unsigned DATA_WIDTH      = 32;
    localparam int unsigned DMEM_ADDR_WIDTH = 32;

    // RISC-V funct3 encodings for loads and stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dmem_state_e;

    typedef struct packed {
        logic                       we;
        logic [DMEM_ADDR_WIDTH-1:0] addr;
        logic [2:0]                 funct3;
        logic [DATA_WIDTH-1:0]      wdata;
    } dmem_req_t;

    typedef struct packed {
        logic                  rvalid;
        logic                  err;
        logic [DATA_WIDTH-1:0] rdata;
    } dmem_rsp_t;

    localparam dmem_req_t REQ_NONE = '{we: 1'b0, addr: 32'h0000_0000, funct3: 3'b000, wdata: 32'h0000_0000};
    localparam dmem_rsp_t RSP_NONE = '{rvalid: 1'b0, err: 1'b0, rdata: 32'h0000_0000};

    // Widen a byte (half_i=0, v_i[7:0]) or half-word (half_i=1) to 32 bits.
    function automatic logic [DATA_WIDTH-1:0] dmem_extend(input logic [15:0] v_i,
                                                         input logic        half_i,
                                                         input logic        sgn_i);
        logic [DATA_WIDTH-1:0] r;
        if (half_i) begin
            r = sgn_i ? {{16{v_i[15]}}, v_i} : {16'h0000, v_i};
        end else begin
            r = sgn_i ? {{24{v_i[7]}}, v_i[7:0]} : {24'h00_0000, v_i[7:0]};
        end
        return r;
    endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: store byte enables and replicated data, load
// extraction/extension, and misalignment / illegal-funct3 detection.
module dmem_lane_align
    import dmem_responder_pkg::*;
(
    input  logic                  we_i,
    input  logic [2:0]            funct3_i,
    input  logic [1:0]            lane_i,
    input  logic [DATA_WIDTH-1:0] wdata_i,
    input  logic [DATA_WIDTH-1:0] rword_i,
    output logic [3:0]            be_o,
    output logic [DATA_WIDTH-1:0] wdata_o,
    output logic [DATA_WIDTH-1:0] rdata_o,
    output logic                  bad_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Pick the addressed byte and half-word out of the stored word.
    always_comb begin
        byte_s = rword_i[{lane_i, 3'b000} +: 8];
        half_s = lane_i[1] ? rword_i[31:16] : rword_i[15:0];
    end

    // Decode access type into lane enables, aligned load data and error flag.
    always_comb begin
        be_o    = 4'b0000;
        wdata_o = {DATA_WIDTH{1'b0}};
        rdata_o = {DATA_WIDTH{1'b0}};
        bad_o   = 1'b0;
        case ({we_i, funct3_i})
            {1'b1, F3_SB}: begin
                be_o    = 4'b0001 << lane_i;
                wdata_o = {4{wdata_i[7:0]}};
            end
            {1'b1, F3_SH}: begin
                be_o    = lane_i[1] ? 4'b1100 : 4'b0011;
                wdata_o = {2{wdata_i[15:0]}};
                bad_o   = lane_i[0];
            end
            {1'b1, F3_SW}: begin
                be_o    = 4'b1111;
                wdata_o = wdata_i;
                bad_o   = (lane_i != 2'b00);
            end
            {1'b0, F3_LB}:  rdata_o = dmem_extend({8'h00, byte_s}, 1'b0, 1'b1);
            {1'b0, F3_LBU}: rdata_o = dmem_extend({8'h00, byte_s}, 1'b0, 1'b0);
            {1'b0, F3_LH}: begin
                rdata_o = dmem_extend(half_s, 1'b1, 1'b1);
                bad_o   = lane_i[0];
            end
            {1'b0, F3_LHU}: begin
                rdata_o = dmem_extend(half_s, 1'b1, 1'b0);
                bad_o   = lane_i[0];
            end
            {1'b0, F3_LW}: begin
                rdata_o = rword_i;
                bad_o   = (lane_i != 2'b00);
            end
            default: bad_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder with programmable wait states.
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int unsigned                DEPTH_WORDS = 1024,
    parameter int unsigned                WAIT_CYCLES = 0,
    parameter logic [DMEM_ADDR_WIDTH-1:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       req_i,
    input  logic                       we_i,
    input  logic [DMEM_ADDR_WIDTH-1:0] addr_i,
    input  logic [2:0]                 funct3_i,
    input  logic [DATA_WIDTH-1:0]      wdata_i,
    output logic                       gnt_o,
    output logic                       rvalid_o,
    output logic [DATA_WIDTH-1:0]      rdata_o,
    output logic                       err_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [DMEM_ADDR_WIDTH:0] LIMIT =
        (DMEM_ADDR_WIDTH + 1)'(64'd4 * 64'(DEPTH_WORDS));
    localparam logic [3:0] WAIT_LAST =
        (WAIT_CYCLES > 32'd0) ? 4'(WAIT_CYCLES - 32'd1) : 4'd0;

    dmem_state_e           state_q;
    dmem_req_t             req_q;
    dmem_req_t             cur_s;
    dmem_rsp_t             rsp_q;
    dmem_rsp_t             rsp_d;
    logic                  gnt_q;
    logic [3:0]            cnt_q;
    logic [DATA_WIDTH-1:0] mem_q [DEPTH_WORDS];

    logic [DMEM_ADDR_WIDTH-1:0] offset_s;
    logic [IDX_W-1:0]           idx_s;
    logic                       oor_s;
    logic                       bad_s;
    logic                       err_s;
    logic                       enter_resp_s;
    logic                       mem_we_s;
    logic [3:0]                 be_s;
    logic [DATA_WIDTH-1:0]      wrep_s;
    logic [DATA_WIDTH-1:0]      load_s;

    // With zero wait states the access completes on the accepting edge, so
    // the live inputs are used while idle and the latched copy afterwards.
    always_comb begin
        if (state_q == IDLE) begin
            cur_s = {we_i, addr_i, funct3_i, wdata_i};
        end else begin
            cur_s = req_q;
        end
        offset_s = cur_s.addr - BASE_ADDR;
        idx_s    = offset_s[IDX_W+1:2];
        oor_s    = (cur_s.addr < BASE_ADDR) || ({1'b0, offset_s} >= LIMIT);
    end

    dmem_lane_align u_align (
        .we_i     (cur_s.we),
        .funct3_i (cur_s.funct3),
        .lane_i   (offset_s[1:0]),
        .wdata_i  (cur_s.wdata),
        .rword_i  (mem_q[idx_s]),
        .be_o     (be_s),
        .wdata_o  (wrep_s),
        .rdata_o  (load_s),
        .bad_o    (bad_s)
    );

    // Decide when RESP is entered and what response gets registered then.
    always_comb begin
        err_s = oor_s || bad_s;
        if (state_q == IDLE) begin
            enter_resp_s = req_i && gnt_q && (WAIT_CYCLES == 32'd0);
        end else if (state_q == WAIT) begin
            enter_resp_s = (cnt_q == WAIT_LAST);
        end else begin
            enter_resp_s = 1'b0;
        end
        mem_we_s     = enter_resp_s && rst_ni && cur_s.we && !err_s;
        rsp_d.rvalid = 1'b1;
        rsp_d.err    = err_s;
        if (err_s || cur_s.we) begin
            rsp_d.rdata = {DATA_WIDTH{1'b0}};
        end else begin
            rsp_d.rdata = load_s;
        end
    end

    // Handshake FSM with wait counter and registered response outputs.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
            gnt_q   <= 1'b1;
            cnt_q   <= 4'd0;
            req_q   <= REQ_NONE;
            rsp_q   <= RSP_NONE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req_i && gnt_q) begin
                        req_q <= cur_s;
                        gnt_q <= 1'b0;
                        cnt_q <= 4'd0;
                        if (enter_resp_s) begin
                            state_q <= RESP;
                            rsp_q   <= rsp_d;
                        end else begin
                            state_q <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (enter_resp_s) begin
                        state_q <= RESP;
                        cnt_q   <= 4'd0;
                        rsp_q   <= rsp_d;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                RESP: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b1;
                    rsp_q   <= RSP_NONE;
                end
                default: begin
                    state_q <= IDLE;
                    gnt_q   <= 1'b1;
                    cnt_q   <= 4'd0;
                    rsp_q   <= RSP_NONE;
                end
            endcase
        end
    end

    // Byte-lane store into the array on the RESP-entry edge; never reset.
    always_ff @(posedge clk_i) begin
        if (mem_we_s) begin
            for (int i = 0; i < 4; i++) begin
                if (be_s[i]) begin
                    mem_q[idx_s][8*i +: 8] <= wrep_s[8*i +: 8];
                end
            end
        end
    end

    assign gnt_o    = gnt_q;
    assign rvalid_o = rsp_q.rvalid;
    assign rdata_o  = rsp_q.rdata;
    assign err_o    = rsp_q.err;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench: two responders (0 and 3 wait states) against a byte-level model.
module tb_dmem_responder;
    import dmem_responder_pkg::*;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] BASE0 = 32'h0000_0000;
    localparam logic [31:0] BASE1 = 32'h0000_1000;
    localparam int          W1    = 3;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [2:0]  f3;
        logic [31:0] wd;
        logic [31:0] rd;
        logic        er;
    } vec_t;

    localparam vec_t DIR_TBL [13] = '{
        '{1'b1, 32'h10, F3_SW,  32'hDEAD_BEEF, 32'h0000_0000, 1'b0},
        '{1'b0, 32'h10, F3_LW,  32'h0000_0000, 32'hDEAD_BEEF, 1'b0},
        '{1'b1, 32'h11, F3_SB,  32'hFFFF_FF55, 32'h0000_0000, 1'b0},
        '{1'b0, 32'h10, F3_LW,  32'h0000_0000, 32'hDEAD_55EF, 1'b0},
        '{1'b0, 32'h11, F3_LB,  32'h0000_0000, 32'h0000_0055, 1'b0},
        '{1'b1, 32'h13, F3_SB,  32'h0000_0080, 32'h0000_0000, 1'b0},
        '{1'b0, 32'h13, F3_LB,  32'h0000_0000, 32'hFFFF_FF80, 1'b0},
        '{1'b0, 32'h13, F3_LBU, 32'h0000_0000, 32'h0000_0080, 1'b0},
        '{1'b1, 32'h12, F3_SH,  32'hBEEF_1234, 32'h0000_0000, 1'b0},
        '{1'b0, 32'h12, F3_LHU, 32'h0000_0000, 32'h0000_1234, 1'b0},
        '{1'b0, 32'h11, F3_LW,  32'h0000_0000, 32'h0000_0000, 1'b1},
        '{1'b1, 32'h13, F3_SH,  32'h0000_ABCD, 32'h0000_0000, 1'b1},
        '{1'b0, 32'h10, F3_LW,  32'h0000_0000, 32'h1234_55EF, 1'b0}
    };

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_a  [2];
    logic        we_a   [2];
    logic [31:0] addr_a [2];
    logic [2:0]  f3_a   [2];
    logic [31:0] wd_a   [2];
    logic        gnt0, gnt1, rv0, rv1, err0, err1;
    logic [31:0] rd0, rd1;
    wire  [1:0]  gnt_v = {gnt1, gnt0};
    wire  [1:0]  rv_v  = {rv1, rv0};
    wire  [1:0]  err_v = {err1, err0};

    int          vectors     = 0;
    int          miscompares = 0;
    int          cyc         = 0;
    logic [7:0]  mdl [2][256];

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(BASE0)) dut0 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a[0]), .we_i(we_a[0]), .addr_i(addr_a[0]),
        .funct3_i(f3_a[0]), .wdata_i(wd_a[0]), .gnt_o(gnt0), .rvalid_o(rv0), .rdata_o(rd0), .err_o(err0));

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W1), .BASE_ADDR(BASE1)) dut1 (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_a[1]), .we_i(we_a[1]), .addr_i(addr_a[1]),
        .funct3_i(f3_a[1]), .wdata_i(wd_a[1]), .gnt_o(gnt1), .rvalid_o(rv1), .rdata_o(rd1), .err_o(err1));

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] base_of(input int s);
        return (s == 0) ? BASE0 : BASE1;
    endfunction

    function automatic int lat_of(input int s);
        return (s == 0) ? 1 : 1 + W1;
    endfunction

    function automatic logic [31:0] rd_of(input int s);
        return (s == 0) ? rd0 : rd1;
    endfunction

    // Byte-addressed reference: legality, range, alignment, little-endian assembly.
    task automatic ref_model(input int s, input logic we, input logic [31:0] addr,
                             input logic [2:0] f3, input logic [31:0] wd,
                             output logic [31:0] rd, output logic er);
        longint      off;
        int          size;
        logic [31:0] v;
        off  = longint'({32'd0, addr}) - longint'({32'd0, base_of(s)});
        size = (f3[1:0] == 2'd0) ? 1 : ((f3[1:0] == 2'd1) ? 2 : 4);
        er   = 1'b0;
        if (we && !(f3 inside {3'd0, 3'd1, 3'd2})) er = 1'b1;
        if (!we && !(f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5})) er = 1'b1;
        if (off < 0 || off >= 4 * DEPTH) er = 1'b1;
        else if ((off % size) != 0) er = 1'b1;
        rd = 32'h0;
        if (!er) begin
            if (we) begin
                for (int i = 0; i < size; i++) mdl[s][int'(off) + i] = wd[8*i +: 8];
            end else begin
                v = 32'h0;
                for (int i = 0; i < size; i++) v[8*i +: 8] = mdl[s][int'(off) + i];
                if (f3 == 3'd0 && v[7])  v[31:8]  = 24'hFF_FFFF;
                if (f3 == 3'd1 && v[15]) v[31:16] = 16'hFFFF;
                rd = v;
            end
        end
    endtask

    // Drive one request, wait for grant and response; report data and cycle stamps.
    task automatic access(input int s, input logic we, input logic [31:0] addr,
                          input logic [2:0] f3, input logic [31:0] wd,
                          output logic [31:0] rd, output logic er,
                          output int acc_c, output int rv_c);
        int n;
        @(negedge clk);
        req_a[s] = 1'b1; we_a[s] = we; addr_a[s] = addr; f3_a[s] = f3; wd_a[s] = wd;
        n = 0;
        while (!gnt_v[s] && n < 64) begin
            @(negedge clk);
            n++;
        end
        acc_c = cyc;
        if (!gnt_v[s]) begin
            vectors++; miscompares++;
            $display("FAIL grant_timeout dut%0d got=no grant exp=grant", s);
        end
        @(posedge clk);
        #1;
        req_a[s] = 1'b0; we_a[s] = 1'($urandom); addr_a[s] = $urandom;
        f3_a[s] = 3'($urandom); wd_a[s] = $urandom;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!rv_v[s] && n < 64);
        rv_c = cyc;
        rd   = rd_of(s);
        er   = err_v[s];
        if (!rv_v[s]) begin
            vectors++; miscompares++;
            $display("FAIL rvalid_timeout dut%0d got=no rvalid exp=rvalid", s);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 2; s++) begin
            vectors++; if (gnt_v[s] !== 1'b1) begin miscompares++; $display("FAIL reset_gnt dut%0d got=%b exp=1", s, gnt_v[s]); end
            vectors++; if (rv_v[s] !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid dut%0d got=%b exp=0", s, rv_v[s]); end
            vectors++; if (err_v[s] !== 1'b0) begin miscompares++; $display("FAIL reset_err dut%0d got=%b exp=0", s, err_v[s]); end
            vectors++; if (rd_of(s) !== 32'h0) begin miscompares++; $display("FAIL reset_rdata dut%0d got=%h exp=0", s, rd_of(s)); end
        end
    endtask

    task automatic test_fill();
        logic [31:0] rd, erd, d;
        logic        er, eer;
        int          a, r;
        for (int s = 0; s < 2; s++) begin
            for (int w = 0; w < int'(DEPTH); w++) begin
                d = $urandom;
                access(s, 1'b1, base_of(s) + 32'(4 * w), F3_SW, d, rd, er, a, r);
                ref_model(s, 1'b1, base_of(s) + 32'(4 * w), F3_SW, d, erd, eer);
                vectors++; if (er !== 1'b0 || rd !== 32'h0) begin miscompares++; $display("FAIL fill dut%0d w%0d got=%b/%h exp=0/0", s, w, er, rd); end
            end
        end
    endtask

    task automatic test_directed();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          a, r;
        for (int i = 0; i < 13; i++) begin
            access(0, DIR_TBL[i].we, DIR_TBL[i].addr, DIR_TBL[i].f3, DIR_TBL[i].wd, rd, er, a, r);
            ref_model(0, DIR_TBL[i].we, DIR_TBL[i].addr, DIR_TBL[i].f3, DIR_TBL[i].wd, erd, eer);
            vectors++; if (rd !== DIR_TBL[i].rd) begin miscompares++; $display("FAIL dir_rdata[%0d] got=%h exp=%h", i, rd, DIR_TBL[i].rd); end
            vectors++; if (er !== DIR_TBL[i].er) begin miscompares++; $display("FAIL dir_err[%0d] got=%b exp=%b", i, er, DIR_TBL[i].er); end
            vectors++; if (r - a !== 1) begin miscompares++; $display("FAIL dir_latency[%0d] got=%0d exp=1", i, r - a); end
        end
    endtask

    task automatic test_wait_states();
        logic [31:0] erd;
        logic        eer;
        int          n;
        ref_model(1, 1'b0, BASE1, F3_LW, 32'h0, erd, eer);
        @(negedge clk);
        req_a[1] = 1'b1; we_a[1] = 1'b0; addr_a[1] = BASE1; f3_a[1] = F3_LW; wd_a[1] = 32'h0;
        n = 0;
        while (!gnt_v[1] && n < 64) begin
            @(negedge clk);
            n++;
        end
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k >= 6) req_a[1] = 1'b0;
            vectors++; if (gnt_v[1] !== 1'(k == 5)) begin miscompares++; $display("FAIL hold_gnt k=%0d got=%b exp=%b", k, gnt_v[1], k == 5); end
            vectors++; if (rv_v[1] !== 1'(k == 4 || k == 9)) begin miscompares++; $display("FAIL hold_rvalid k=%0d got=%b exp=%b", k, rv_v[1], k == 4 || k == 9); end
            if (k == 4 || k == 9) begin
                vectors++; if (rd1 !== erd || err1 !== 1'b0) begin miscompares++; $display("FAIL hold_rdata k=%0d got=%h/%b exp=%h/0", k, rd1, err1, erd); end
            end
        end
    endtask

    task automatic test_out_of_range();
        logic [31:0] rd, erd;
        logic        er, eer;
        int          a, r;
        logic [31:0] oor_addr [4];
        int          oor_sel  [4];
        oor_addr = '{32'h0000_0100, 32'hFFFF_FFFC, BASE1 - 32'd4, BASE1 + 32'h100};
        oor_sel  = '{0, 0, 1, 1};
        for (int i = 0; i < 4; i++) begin
            access(oor_sel[i], 1'b1, oor_addr[i], F3_SW, $urandom, rd, er, a, r);
            vectors++; if (er !== 1'b1 || rd !== 32'h0) begin miscompares++; $display("FAIL oor_err[%0d] got=%b/%h exp=1/0", i, er, rd); end
        end
        for (int s = 0; s < 2; s++) begin
            ref_model(s, 1'b0, base_of(s), F3_LW, 32'h0, erd, eer);
            access(s, 1'b0, base_of(s), F3_LW, 32'h0, rd, er, a, r);
            vectors++; if (rd !== erd || er !== 1'b0) begin miscompares++; $display("FAIL oor_nowrite dut%0d got=%h exp=%h", s, rd, erd); end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] rd, erd, d;
        logic        er, eer;
        int          a, r, seen;
        @(negedge clk);
        req_a[1] = 1'b1; we_a[1] = 1'b1; addr_a[1] = BASE1 + 32'h20; f3_a[1] = F3_SW; wd_a[1] = ~32'(mdl[1][32]);
        @(posedge clk);
        #1 req_a[1] = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++; if (gnt1 !== 1'b1 || rv1 !== 1'b0) begin miscompares++; $display("FAIL midrst_outputs got=%b/%b exp=1/0", gnt1, rv1); end
        @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (rv1) seen++;
        end
        vectors++; if (seen !== 0) begin miscompares++; $display("FAIL midrst_rvalid got=%0d pulses exp=0", seen); end
        ref_model(1, 1'b0, BASE1 + 32'h20, F3_LW, 32'h0, erd, eer);
        access(1, 1'b0, BASE1 + 32'h20, F3_LW, 32'h0, rd, er, a, r);
        vectors++; if (rd !== erd) begin miscompares++; $display("FAIL midrst_mem got=%h exp=%h", rd, erd); end
        d = $urandom;
        access(0, 1'b1, 32'h40, F3_SW, d, rd, er, a, r);
        ref_model(0, 1'b1, 32'h40, F3_SW, d, erd, eer);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        access(0, 1'b0, 32'h40, F3_LW, 32'h0, rd, er, a, r);
        vectors++; if (rd !== d) begin miscompares++; $display("FAIL resprst_commit got=%h exp=%h", rd, d); end
    endtask

    task automatic test_back_to_back();
        logic [31:0] rd;
        logic        er;
        int          a0, r0, a1, r1;
        for (int s = 0; s < 2; s++) begin
            access(s, 1'b0, base_of(s) + 32'h8, F3_LW, 32'h0, rd, er, a0, r0);
            access(s, 1'b0, base_of(s) + 32'hC, F3_LW, 32'h0, rd, er, a1, r1);
            vectors++; if (a1 - r0 !== 1) begin miscompares++; $display("FAIL b2b_grant dut%0d got=%0d exp=1", s, a1 - r0); end
            vectors++; if (a1 - a0 !== lat_of(s) + 1) begin miscompares++; $display("FAIL b2b_period dut%0d got=%0d exp=%0d", s, a1 - a0, lat_of(s) + 1); end
        end
    endtask

    task automatic test_random();
        logic [31:0] rd, erd, addr, wd;
        logic        er, eer, we;
        logic [2:0]  f3;
        int          s, a, r, sel;
        for (int i = 0; i < 200; i++) begin
            s   = int'($urandom_range(0, 1));
            we  = 1'($urandom);
            f3  = 3'($urandom);
            wd  = $urandom;
            sel = int'($urandom_range(0, 9));
            if (sel == 0)      addr = base_of(s) - 32'($urandom_range(1, 8));
            else if (sel == 1) addr = base_of(s) + 32'h100 + 32'($urandom_range(0, 7));
            else               addr = base_of(s) + 32'($urandom_range(0, 255));
            access(s, we, addr, f3, wd, rd, er, a, r);
            ref_model(s, we, addr, f3, wd, erd, eer);
            vectors++; if (rd !== erd || er !== eer) begin miscompares++; $display("FAIL rand[%0d] dut%0d we=%b a=%h f3=%0d got=%h/%b exp=%h/%b", i, s, we, addr, f3, rd, er, erd, eer); end
            vectors++; if (r - a !== lat_of(s)) begin miscompares++; $display("FAIL rand_latency[%0d] got=%0d exp=%0d", i, r - a, lat_of(s)); end
            @(negedge clk);
            vectors++; if (rv_v[s] !== 1'b0) begin miscompares++; $display("FAIL rand_pulse[%0d] got=%b exp=0", i, rv_v[s]); end
        end
    endtask

    initial begin
        for (int s = 0; s < 2; s++) begin
            req_a[s] = 1'b0; we_a[s] = 1'b0; addr_a[s] = 32'h0; f3_a[s] = 3'd0; wd_a[s] = 32'h0;
        end
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_fill();
        test_directed();
        test_wait_states();
        test_out_of_range();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "simulation watchdog expired");
    end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Data-memory responder serving the CPU's MEM-stage load/store port.
- Accepts one request at a time over a req/gnt/rvalid handshake.
- Applies programmable wait states, performs byte-lane writes for SB/SH/SW, and returns LB/LH/LW/LBU/LHU data already aligned and extended.
- Flags misaligned and out-of-range accesses.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words in the memory array (power of two).
- WAIT_CYCLES, 0, extra cycles between grant and response (0..15).
- BASE_ADDR, 32'h0000_0000, byte address mapped to word 0.

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- req_i  in  1  request valid from CPU.
- we_i  in  1  1 = store, 0 = load.
- addr_i  in  32  byte address.
- funct3_i  in  3  access type, RISC-V funct3 encoding (LB/LH/LW/LBU/LHU, SB/SH/SW).
- wdata_i  in  DATA_WIDTH  store data, right-aligned (byte in [7:0], half in [15:0]).
- gnt_o  out  1  request accepted this cycle.
- rvalid_o  out  1  response valid, one-cycle pulse.
- rdata_o  out  DATA_WIDTH  load result; 0 for stores and errors.
- err_o  out  1  valid with rvalid_o; misaligned, out of range, or illegal funct3.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state = IDLE; gnt_o = 1; rvalid_o = 0; rdata_o = 0; err_o = 0; wait counter = 0.
  - Memory array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - gnt_o = 1 (combinational from state only; no dependence on req_i).
  - On req_i && gnt_o, latch we_i, addr_i, funct3_i and wdata_i.
  - Go to WAIT if WAIT_CYCLES > 0, else RESP.
- WAIT:
  - gnt_o = 0; counter increments each cycle.
  - Move to RESP on the cycle the counter equals WAIT_CYCLES-1.
- Entry to RESP (the clock edge that enters RESP):
  - Perform the memory write, or register the load result into rdata_o.
  - err_o is also registered on this edge.
- RESP:
  - rvalid_o = 1 for exactly one cycle; gnt_o = 0; next state IDLE.
  - Latency: accept at cycle N gives rvalid_o at cycle N+1+WAIT_CYCLES.
  - Maximum throughput: one access per WAIT_CYCLES+2 cycles.
- Address decode:
  - offset = addr - BASE_ADDR; word index = offset[..:2]; byte lane = offset[1:0].
  - Out of range if addr < BASE_ADDR or offset >= 4*DEPTH_WORDS.
- Alignment rules:
  - Half accesses need lane[0] = 0.
  - Word accesses need lane = 00.
  - Byte accesses are always aligned.
- Error response:
  - Any misaligned, out-of-range or illegal funct3 (3'b011, 3'b110, 3'b111; and 3'b100/3'b101 with we=1) sets err_o = 1 with rvalid_o.
  - No memory write occurs; rdata_o = 0.
- Stores:
  - Byte-enable mask from funct3/lane: SB = 1 lane; SH = lanes {1:0} or {3:2}; SW = all four.
  - wdata is replicated onto the enabled lanes; unselected bytes are unchanged.
  - rdata_o = 0.
- Loads:
  - Select the lane(s) of the addressed word.
  - LB/LH sign-extend to 32 bits; LBU/LHU zero-extend; LW passes through.
- req_i is ignored while gnt_o = 0.
- The CPU holds req_i until granted; a request deasserted before grant is simply not seen.
- Reset asserted mid-transaction:
  - The in-flight access is abandoned and no rvalid_o is produced.
  - A store is committed only if its RESP-entry edge occurred before reset assertion.
- Back-to-back: a request presented in the IDLE cycle right after RESP is granted immediately.

Decomposition:
- Shared package additions:
  - DMEM_ADDR_WIDTH.
  - Typedef dmem_req_t {we, addr, funct3, wdata}.
  - Typedef dmem_rsp_t {rvalid, err, rdata}.
  - State enum dmem_state_e {IDLE, WAIT, RESP}.
  - Reuse the existing LB..LHU/SB..SW funct3 constants.
- One natural sub-module, dmem_lane_align:
  - Combinational block producing the byte-enable mask and shifted store data.
  - Extracts and extends load data from word + lane + funct3.
  - Computes the misalign/illegal flag.
- The FSM, counter and memory array live in the top.

Test Plan:
- Reset, then idle with WAIT_CYCLES=0 -> gnt_o=1, rvalid_o=0, rdata_o=0, err_o=0.
- SW addr 0x10 data 0xDEADBEEF, then LW 0x10 (WAIT_CYCLES=0) -> each rvalid_o one cycle after grant; LW returns 0xDEADBEEF, err_o=0.
- After the above: SB 0x11 data 0x55, LW 0x10 -> 0xDEAD55EF; LB 0x11 -> 0x00000055; SB 0x13 data 0x80, LB 0x13 -> 0xFFFFFF80, LBU 0x13 -> 0x00000080.
- SH 0x12 data 0x1234, LHU 0x12 -> 0x00001234; LW 0x11 -> err_o=1, rdata_o=0; SH 0x13 -> err_o=1 and word at 0x10 unchanged.
- WAIT_CYCLES=3: LW accepted at cycle 10 -> rvalid_o exactly at cycle 14; req_i held high in cycles 11-14 is not granted; next grant at cycle 15.
- SW to addr 4*DEPTH_WORDS -> err_o=1, no write; reset asserted in WAIT of an SW -> no rvalid_o, and memory unchanged on a subsequent LW.
